// File: rtl/msrv32_pkg.sv
// Shared encodings for the data-memory access path: access sizes, FSM states,
// byte-lane select/strobe constants and the alignment rule.
package msrv32_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RSP  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  localparam logic [1:0] LANE_B0 = 2'd0;
  localparam logic [1:0] LANE_B1 = 2'd1;
  localparam logic [1:0] LANE_B2 = 2'd2;
  localparam logic [1:0] LANE_B3 = 2'd3;

  localparam logic [3:0] STRB_BYTE    = 4'b0001;
  localparam logic [3:0] STRB_HALF_LO = 4'b0011;
  localparam logic [3:0] STRB_HALF_HI = 4'b1100;
  localparam logic [3:0] STRB_WORD    = 4'b1111;

  // Reserved size is treated as misaligned so it never reaches the bus.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic mis;
    mis = 1'b1;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = lo[0];
      SIZE_WORD: mis = (lo != 2'b00);
      default:   mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/msrv32_load_align.sv
// Selects the addressed byte/half lane of a read word and sign/zero-extends it.
// Purely combinational; no flow control.
module msrv32_load_align
  import msrv32_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        zero_ext,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      LANE_B1: byte_sel = rdata[15:8];
      LANE_B2: byte_sel = rdata[23:16];
      LANE_B3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = rdata;
    case (size)
      SIZE_BYTE: data = {{24{~zero_ext & byte_sel[7]}}, byte_sel};
      SIZE_HALF: data = {{16{~zero_ext & half_sel[15]}}, half_sel};
      default:   data = rdata;
    endcase
  end

endmodule

// File: rtl/msrv32_dmem_access_unit.sv
// Load/store data-bus sequencer: IDLE->REQ->RSP->DONE, result pulses in DONE (3 cycles zero-wait).
// Holds the request stable until grant; stalls the pipeline while in flight; RSP times out to a bus error.
module msrv32_dmem_access_unit
  import msrv32_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255  // 1..255
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        mem_req_in,
  input  logic        mem_wr_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  input  logic [1:0]  size_in,
  input  logic        load_unsigned_in,
  input  logic        flush_in,
  output logic        dbus_req_out,
  output logic        dbus_we_out,
  output logic [31:0] dbus_addr_out,
  output logic [31:0] dbus_wdata_out,
  output logic [3:0]  dbus_wstrb_out,
  input  logic        dbus_gnt_in,
  input  logic        dbus_rvalid_in,
  input  logic        dbus_err_in,
  input  logic [31:0] dbus_rdata_in,
  output logic        stall_out,
  output logic [31:0] load_data_out,
  output logic        load_valid_out,
  output logic        misaligned_out,
  output logic        bus_err_out
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q;
  logic [31:0] addr_q, wdata_q, wdata_d, load_word;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  size_q;
  logic        we_q, uns_q;
  logic        stall, issue, mis_take, timeout;
  logic        in_req;

  always_comb begin
    wdata_d = store_data_in;
    wstrb_d = STRB_WORD;
    case (size_in)
      SIZE_BYTE: begin
        wdata_d = {4{store_data_in[7:0]}};
        wstrb_d = STRB_BYTE << addr_in[1:0];
      end
      SIZE_HALF: begin
        wdata_d = {2{store_data_in[15:0]}};
        wstrb_d = addr_in[1] ? STRB_HALF_HI : STRB_HALF_LO;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    issue    = 1'b0;
    mis_take = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_req_in && !flush_in) begin
          stall = 1'b1;
          if (is_misaligned(size_in, addr_in[1:0])) begin
            mis_take = 1'b1;
            state_d  = ST_DONE;
          end else begin
            issue   = 1'b1;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        stall = 1'b1;
        if (dbus_gnt_in) state_d = ST_RSP;
      end
      ST_RSP: begin
        stall = 1'b1;
        if (dbus_rvalid_in) begin
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Result flags are one-shot: set on the edge into DONE, dropped on the edge out.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      cnt_q          <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      size_q         <= '0;
      we_q           <= 1'b0;
      uns_q          <= 1'b0;
      load_data_out  <= '0;
      load_valid_out <= 1'b0;
      misaligned_out <= 1'b0;
      bus_err_out    <= 1'b0;
    end else begin
      load_valid_out <= 1'b0;
      misaligned_out <= mis_take;
      bus_err_out    <= timeout;
      if (issue) begin
        addr_q  <= addr_in;
        wdata_q <= wdata_d;
        wstrb_q <= mem_wr_in ? wstrb_d : 4'b0000;
        size_q  <= size_in;
        we_q    <= mem_wr_in;
        uns_q   <= load_unsigned_in;
      end
      if (state_q == ST_REQ) cnt_q <= '0;
      if (state_q == ST_RSP) begin
        cnt_q <= cnt_q + 8'd1;
        if (dbus_rvalid_in) begin
          if (dbus_err_in) begin
            bus_err_out   <= 1'b1;
            load_data_out <= '0;
          end else if (!we_q) begin
            load_valid_out <= 1'b1;
            load_data_out  <= load_word;
          end
        end
      end
    end
  end

  msrv32_load_align u_load_align (
    .rdata    (dbus_rdata_in),
    .addr_lo  (addr_q[1:0]),
    .size     (size_q),
    .zero_ext (uns_q),
    .data     (load_word)
  );

  assign in_req         = (state_q == ST_REQ);
  assign dbus_req_out   = in_req;
  assign dbus_we_out    = in_req & we_q;
  assign dbus_addr_out  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign dbus_wdata_out = in_req ? wdata_q : 32'h0;
  assign dbus_wstrb_out = in_req ? wstrb_q : 4'b0000;
  assign stall_out      = stall & reset_in;

endmodule

// File: doc/msrv32_dmem_access_unit.md
MSRV32_DMEM_ACCESS_UNIT -- requirements
Module: msrv32_dmem_access_unit

Interface
REQ-001 Parameter SHALL be: TIMEOUT_CYCLES, 255, max RSP-state cycles before bus error (1..255).
REQ-002 clk_in  input  1  sole clock, rising edge.
REQ-003 reset_in  input  1  asynchronous, active-low reset.
REQ-004 mem_req_in  input  1  stage-2 instruction is a valid load/store.
REQ-005 mem_wr_in  input  1  1=store, 0=load.
REQ-006 addr_in  input  32  effective byte address from the stage-2 iadder output.
REQ-007 store_data_in  input  32  rs2 value.
REQ-008 size_in  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-009 load_unsigned_in  input  1  1=zero-extend, 0=sign-extend.
REQ-010 flush_in  input  1  trap/kill; blocks issue in IDLE only.
REQ-011 dbus_req_out, dbus_we_out  output  1 each  bus request, write enable.
REQ-012 dbus_addr_out  output  32  word-aligned address ({addr[31:2],2'b00}).
REQ-013 dbus_wdata_out  output  32 / dbus_wstrb_out  output  4  lane-replicated store data, byte strobes.
REQ-014 dbus_gnt_in, dbus_rvalid_in, dbus_err_in  input  1 each  accept, response valid, response error.
REQ-015 dbus_rdata_in  input  32  read word.
REQ-016 stall_out  output  1  hold pipeline.
REQ-017 load_data_out  output  32 / load_valid_out, misaligned_out, bus_err_out  output  1 each  completion results, DONE-cycle pulses.

Function
REQ-018 FSM SHALL have states IDLE, REQ, RSP, DONE.
REQ-019 IDLE: mem_req_in & !flush_in & aligned -> capture addr/data/size/we/unsigned, go REQ; misaligned -> go DONE with misaligned flag; otherwise stay.
REQ-020 Misaligned SHALL be: half with addr[0]=1, word with addr[1:0]!=0, or size 11; no bus request issued.
REQ-021 REQ: dbus_req_out=1 with addr/we/wdata/wstrb stable until dbus_gnt_in sampled high -> RSP; flush_in ignored.
REQ-022 RSP: counter increments each cycle; dbus_rvalid_in -> DONE; counter reaching TIMEOUT_CYCLES -> DONE with bus_err_out; rvalid in IDLE/REQ/DONE ignored.
REQ-023 DONE: one cycle, the selected pulse(s) high, then IDLE; no issue taken in DONE (prevents re-issue of the completing instruction).
REQ-024 stall_out SHALL be high in REQ and RSP, and in IDLE when an access or misaligned DONE is being entered; low in DONE.
REQ-025 Store byte: wstrb=1<<addr[1:0], wdata=byte x4; half: wstrb 0011/1100 by addr[1], wdata=half x2; word: 1111.
REQ-026 Load extraction: byte lane addr[1:0], half lane addr[1]; extend per load_unsigned_in; registered into load_data_out on rvalid.
REQ-027 dbus_err_in with rvalid -> bus_err_out in DONE, load_data_out=0; stores pulse load_valid_out=0, complete on rvalid as write-ack.
REQ-028 Zero-wait latency: issue cycle 0, gnt cycle 1, rvalid cycle 2, load_valid_out cycle 3; back-to-back accesses incur a DONE bubble.

Reset
REQ-029 reset_in low SHALL asynchronously force IDLE, counter 0, all outputs 0, including mid-transaction (bus request dropped immediately).

Structure
REQ-030 Size encodings, FSM state encoding and lane-select constants SHALL reside in shared package msrv32_pkg.
REQ-031 Load alignment/extension SHALL be sub-module msrv32_load_align (combinational).

Verification
REQ-032 LB addr 0x103, rdata 0x80FF_FF00, gnt/rvalid zero-wait -> load_data_out 0xFFFF_FF80, load_valid_out at cycle 3.
REQ-033 SH addr 0x202, store_data 0x1234_ABCD, gnt after 3 cycles -> dbus_addr_out 0x200, wstrb 1100, wdata 0xABCD_ABCD held stable until gnt.
REQ-034 LW addr 0x101 -> no dbus_req_out, misaligned_out one cycle, stall_out high one cycle.
REQ-035 LW, TIMEOUT_CYCLES=4, no rvalid -> bus_err_out after 4 RSP cycles, FSM IDLE.
REQ-036 LHU addr 0x002 with reset_in low in RSP -> outputs 0 immediately; late rvalid after release ignored.
REQ-037 flush_in with mem_req_in in IDLE -> no request, stall_out low.
